// File: rtl/pattern_writer_if.sv
// Bundle between a note source and the pattern writer: note handshake, control,
// pattern-RAM write port and status.
interface pattern_writer_if #(
  parameter int ADDR_WIDTH = 8
);
  // Handshake: a note transfers on any rising edge where i_note_valid and
  // o_note_ready are both high; o_note_ready never depends on i_note_valid.
  logic                  i_note_valid;
  logic                  o_note_ready;
  logic [5:0]            i_pitch;
  logic [4:0]            i_duration;
  logic [3:0]            i_instrument;
  logic                  i_finish;
  logic                  i_clear;
  logic                  o_ram_we;
  logic [ADDR_WIDTH-1:0] o_ram_addr;
  logic [15:0]           o_ram_data;
  logic [ADDR_WIDTH:0]   o_count;
  logic                  o_full;
  logic                  o_done;
  logic [1:0]            dbg_state;

  modport master (
    output i_note_valid, i_pitch, i_duration, i_instrument, i_finish, i_clear,
    input  o_note_ready, o_ram_we, o_ram_addr, o_ram_data, o_count, o_full,
           o_done, dbg_state
  );

  modport slave (
    input  i_note_valid, i_pitch, i_duration, i_instrument, i_finish, i_clear,
    output o_note_ready, o_ram_we, o_ram_addr, o_ram_data, o_count, o_full,
           o_done, dbg_state
  );
endinterface

// File: rtl/pattern_writer.sv
// Packs accepted notes into 16-bit pattern words and writes them sequentially,
// closing the pattern with an end-marker word on request.
module pattern_writer #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input logic           i_clk,
  input logic           i_rst_n,
  pattern_writer_if.slave pw
);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    END_PEND = 2'd1,
    DONE     = 2'd2
  } state_t;

  localparam logic [15:0]         END_MARKER = 16'h8000;
  // The last address stays free so the end marker always has a slot.
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [15:0]           ram_data;
  logic                  full;
  logic                  ready;
  logic                  accept;

  assign full   = (count == FULL_COUNT);
  assign ready  = (state == IDLE) && !full && !pw.i_clear;
  assign accept = pw.i_note_valid && ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      count    <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else if (pw.i_clear) begin
      state    <= IDLE;
      ptr      <= '0;
      count    <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      ram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ram_we   <= 1'b1;
            ram_addr <= ptr;
            ram_data <= {1'b0, pw.i_pitch, pw.i_duration, pw.i_instrument};
            ptr      <= ptr + 1'b1;
            count    <= count + 1'b1;
            if (pw.i_finish) state <= END_PEND;
          end else if (pw.i_finish) begin
            ram_we   <= 1'b1;
            ram_addr <= ptr;
            ram_data <= END_MARKER;
            state    <= DONE;
          end
        end
        END_PEND: begin
          // ptr already points one past the note written last cycle.
          ram_we   <= 1'b1;
          ram_addr <= ptr;
          ram_data <= END_MARKER;
          state    <= DONE;
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign pw.o_note_ready = ready;
  assign pw.o_ram_we     = ram_we;
  assign pw.o_ram_addr   = ram_addr;
  assign pw.o_ram_data   = ram_data;
  assign pw.o_count      = count;
  assign pw.o_full       = full;
  assign pw.o_done       = (state == DONE);
  assign pw.dbg_state    = state;
endmodule

// File: tb/tb_pattern_writer.sv
// Directed bench for pattern_writer: a default-size instance and a DEPTH=4
// instance, with a write scoreboard per instance.
module tb_pattern_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [23:0] exp_a[$];
  logic [23:0] exp_s[$];
  logic [7:0]  a_ptr = '0;
  logic [7:0]  s_ptr = '0;

  always #5 clk = ~clk;

  pattern_writer_if #(.ADDR_WIDTH(8)) a_if ();
  pattern_writer_if #(.ADDR_WIDTH(2)) s_if ();

  pattern_writer #(.DEPTH(256), .ADDR_WIDTH(8)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .pw(a_if)
  );
  pattern_writer #(.DEPTH(4), .ADDR_WIDTH(2)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .pw(s_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboards: every write strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (a_if.o_ram_we !== 1'b0) begin
      if (exp_a.size() == 0) check("a_unexpected_we", {31'b0, a_if.o_ram_we}, 32'd0);
      else check("a_write", {8'b0, a_if.o_ram_addr, a_if.o_ram_data}, {8'b0, exp_a.pop_front()});
    end
    if (s_if.o_ram_we !== 1'b0) begin
      if (exp_s.size() == 0) check("s_unexpected_we", {31'b0, s_if.o_ram_we}, 32'd0);
      else check("s_write", {14'b0, s_if.o_ram_addr, s_if.o_ram_data}, {8'b0, exp_s.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_note(input logic [5:0] p, input logic [4:0] d, input logic [3:0] ins,
                        input logic fin);
    a_if.i_note_valid = 1'b1;
    a_if.i_pitch      = p;
    a_if.i_duration   = d;
    a_if.i_instrument = ins;
    a_if.i_finish     = fin;
    exp_a.push_back({a_ptr, 1'b0, p, d, ins});
    a_ptr++;
    if (fin) exp_a.push_back({a_ptr, 16'h8000});
    tick();
    a_if.i_note_valid = 1'b0;
    a_if.i_finish     = 1'b0;
  endtask

  task automatic a_rand_note();
    a_note(6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 1'b0);
  endtask

  task automatic a_finish();
    a_if.i_finish = 1'b1;
    exp_a.push_back({a_ptr, 16'h8000});
    tick();
    a_if.i_finish = 1'b0;
  endtask

  task automatic a_clear(input string tag);
    a_if.i_clear = 1'b1;
    @(negedge clk);
    check({tag, "_ready_during_clear"}, {31'b0, a_if.o_note_ready}, 32'd0);
    tick();
    a_if.i_clear = 1'b0;
    a_ptr = '0;
    @(negedge clk);
    check({tag, "_count_after_clear"}, 32'(a_if.o_count), 32'd0);
    check({tag, "_done_after_clear"}, {31'b0, a_if.o_done}, 32'd0);
  endtask

  task automatic s_note();
    logic [15:0] w;
    w = {1'b0, 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15))};
    s_if.i_note_valid = 1'b1;
    {s_if.i_pitch, s_if.i_duration, s_if.i_instrument} = w[14:0];
    exp_s.push_back({s_ptr, w});
    s_ptr++;
    tick();
    s_if.i_note_valid = 1'b0;
  endtask

  initial begin
    a_if.i_note_valid = 0; a_if.i_pitch = 0; a_if.i_duration = 0; a_if.i_instrument = 0;
    a_if.i_finish = 0; a_if.i_clear = 0;
    s_if.i_note_valid = 0; s_if.i_pitch = 0; s_if.i_duration = 0; s_if.i_instrument = 0;
    s_if.i_finish = 0; s_if.i_clear = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_we", {31'b0, a_if.o_ram_we}, 32'd0);
    check("rst_addr", 32'(a_if.o_ram_addr), 32'd0);
    check("rst_data", 32'(a_if.o_ram_data), 32'd0);
    check("rst_count", 32'(a_if.o_count), 32'd0);
    check("rst_full", {31'b0, a_if.o_full}, 32'd0);
    check("rst_done", {31'b0, a_if.o_done}, 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'b0, a_if.o_note_ready}, 32'd1);

    // Single note
    tick();
    a_note(6'd12, 5'd4, 4'd3, 1'b0);
    @(negedge clk);
    check("single_data_lit", 32'(a_if.o_ram_data), 32'h1843);
    tick();
    @(negedge clk);
    check("single_count", 32'(a_if.o_count), 32'd1);

    // Burst of three then finish
    a_clear("burst");
    tick();
    repeat (3) a_rand_note();
    a_finish();
    @(negedge clk);
    check("burst_done", {31'b0, a_if.o_done}, 32'd1);
    check("burst_count", 32'(a_if.o_count), 32'd3);
    check("burst_ready_done", {31'b0, a_if.o_note_ready}, 32'd0);
    check("burst_state", 32'(a_if.dbg_state), 32'd2);
    // Notes and finish in DONE are ignored
    a_if.i_note_valid = 1'b1;
    a_if.i_finish = 1'b1;
    repeat (2) tick();
    a_if.i_note_valid = 1'b0;
    a_if.i_finish = 1'b0;
    @(negedge clk);
    check("done_ignore_count", 32'(a_if.o_count), 32'd3);

    // Clear in DONE, next note lands at 0
    a_clear("clr_done");
    tick();
    a_rand_note();

    // Simultaneous note and finish at count 5
    a_clear("simul");
    tick();
    repeat (5) a_rand_note();
    a_note(6'd33, 5'd17, 4'd9, 1'b1);
    @(negedge clk);
    check("simul_ready_endpend", {31'b0, a_if.o_note_ready}, 32'd0);
    check("simul_state_endpend", 32'(a_if.dbg_state), 32'd1);
    tick();
    @(negedge clk);
    check("simul_done", {31'b0, a_if.o_done}, 32'd1);
    check("simul_count", 32'(a_if.o_count), 32'd6);

    // Clear in END_PEND discards the marker
    a_clear("pre_endpend");
    tick();
    repeat (2) a_rand_note();
    a_note(6'd1, 5'd2, 4'd3, 1'b1);
    void'(exp_a.pop_back());
    a_clear("clr_endpend");
    repeat (3) tick();
    a_rand_note();
    a_rand_note();
    @(negedge clk);
    check("post_endpend_count", 32'(a_if.o_count), 32'd2);

    // Reset with a note offered: no write may occur
    tick();
    a_if.i_note_valid = 1'b1;
    a_if.i_pitch = 6'd5;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_we", {31'b0, a_if.o_ram_we}, 32'd0);
    check("mid_rst_addr", 32'(a_if.o_ram_addr), 32'd0);
    check("mid_rst_data", 32'(a_if.o_ram_data), 32'd0);
    check("mid_rst_count", 32'(a_if.o_count), 32'd0);
    a_if.i_note_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    a_ptr = '0;
    @(negedge clk);
    check("mid_rst_ready", {31'b0, a_if.o_note_ready}, 32'd1);
    check("mid_rst_done", {31'b0, a_if.o_done}, 32'd0);

    // Small instance: fill to capacity, then finish into the last slot
    tick();
    repeat (3) s_note();
    @(negedge clk);
    check("s_full", {31'b0, s_if.o_full}, 32'd1);
    check("s_ready_full", {31'b0, s_if.o_note_ready}, 32'd0);
    s_if.i_note_valid = 1'b1;
    repeat (2) tick();
    s_if.i_note_valid = 1'b0;
    @(negedge clk);
    check("s_count_full", 32'(s_if.o_count), 32'd3);
    tick();
    s_if.i_finish = 1'b1;
    exp_s.push_back({8'd3, 16'h8000});
    tick();
    s_if.i_finish = 1'b0;
    @(negedge clk);
    check("s_done", {31'b0, s_if.o_done}, 32'd1);
    check("s_count_done", 32'(s_if.o_count), 32'd3);

    repeat (3) tick();
    check("a_queue_empty", 32'(exp_a.size()), 32'd0);
    check("s_queue_empty", 32'(exp_s.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
